tile_wr_responder: RTL and testbench

- Destination-side responder for the XY mesh write-request path. It accepts write requests ejected at this tile and retires each one into the local memory port.
- After each write it returns a completion ack packet toward the originating tile, injected on the X ring or Y ring.
- Acks addressed to this tile go to a local ack port instead.
- It provides the completion handshake the initiator-side cluster fifo needs for store ordering and credit release.

---
 rtl/tile_wr_responder.sv | 100 ++++++++++
 tb/tb_tile_wr_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tile_wr_responder.sv
// tile_wr_responder: retires mesh write requests into local memory and returns
// a completion ack on the X/Y ring, or on the local ack port for this tile's own requests.
module tile_wr_responder #(
  parameter int TILE_X  = 0,
  parameter int TILE_Y  = 0,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic [527:0] req_data,
  input  logic [32:0]  req_addr,
  input  logic [11:0]  req_size,
  input  logic [9:0]   req_src,
  input  logic [3:0]   req_tag,
  output logic         mem_wr_en,
  input  logic         mem_wr_rdy,
  output logic [527:0] mem_wr_data,
  output logic [42:0]  mem_wr_addr,
  output logic [11:0]  mem_wr_size,
  input  logic         mem_wr_done,
  output logic [1:0]   ack_vld,
  input  logic [1:0]   ack_rdy,
  output logic [16:0]  ack_pkt,
  output logic         local_ack_vld,
  output logic [3:0]   local_ack_tag,
  output logic         local_ack_err,
  output logic [7:0]   err_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    timer;
  logic          err, push, pop, in_ack, is_local, xdim, fwd, timeout_hit;
  logic [4:0]    sx, sy;
  logic [527:0]  data_q [DEPTH];
  logic [32:0]   addr_q [DEPTH];
  logic [11:0]   size_q [DEPTH];
  logic [9:0]    src_q  [DEPTH];
  logic [3:0]    tag_q  [DEPTH];
  always_ff @(posedge clk)
    if (push) begin
      data_q[wr_ptr] <= req_data;
      addr_q[wr_ptr] <= req_addr;
      size_q[wr_ptr] <= req_size;
      src_q[wr_ptr]  <= req_src;
      tag_q[wr_ptr]  <= req_tag;
    end
  assign sx          = src_q[rd_ptr][4:0];
  assign sy          = src_q[rd_ptr][9:5];
  assign xdim        = sx != 5'(TILE_X);
  assign is_local    = !xdim && sy == 5'(TILE_Y);
  assign fwd         = xdim ? sx > 5'(TILE_X) : sy > 5'(TILE_Y);
  assign req_rdy     = count != (AW+1)'(DEPTH);
  assign push        = req_vld && req_rdy;
  assign in_ack      = state == ACK;
  assign timeout_hit = state == WAIT && !mem_wr_done && timer == 8'(TIMEOUT - 1);
  assign mem_wr_en   = state == ISSUE;
  assign mem_wr_data = mem_wr_en ? data_q[rd_ptr] : '0;
  assign mem_wr_addr = mem_wr_en ? {5'(TILE_Y), 5'(TILE_X), addr_q[rd_ptr]} : '0;
  assign mem_wr_size = mem_wr_en ? size_q[rd_ptr] : '0;
  assign ack_vld       = in_ack && !is_local ? {fwd, !fwd} : 2'b00;
  assign ack_pkt       = in_ack ? {err, 1'b0, !xdim, sy, sx, tag_q[rd_ptr]} : '0;
  assign local_ack_vld = in_ack && is_local;
  assign local_ack_tag = local_ack_vld ? tag_q[rd_ptr] : '0;
  assign local_ack_err = local_ack_vld && err;
  assign pop           = local_ack_vld || |(ack_vld & ack_rdy);
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = count != '0 ? ISSUE : IDLE;
      ISSUE: state_nxt = mem_wr_rdy ? WAIT : ISSUE;
      WAIT:  state_nxt = mem_wr_done || timeout_hit ? ACK : WAIT;
      ACK:   state_nxt = pop ? IDLE : ACK;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      timer   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      timer  <= state == WAIT ? timer + 8'd1 : 8'd0;
      // err only matters on the WAIT->ACK transition; it then holds through ACK
      if (state == WAIT) err <= !mem_wr_done;
      if (timeout_hit && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
    end
endmodule

// File: tb/tb_tile_wr_responder.sv
// tb_tile_wr_responder: directed and randomized checks of tile_wr_responder
// against a queue-based reference model of ordering, routing and timeout rules.
module tb_tile_wr_responder;
  localparam int TX = 1, TY = 1, DEPTH = 8, TO = 3;
  logic         clk = 0, rst_n = 0;
  logic         req_vld = 0, req_rdy;
  logic [527:0] req_data = '0;
  logic [32:0]  req_addr = '0;
  logic [11:0]  req_size = '0;
  logic [9:0]   req_src = '0;
  logic [3:0]   req_tag = '0;
  logic         mem_wr_en, mem_wr_rdy = 0, mem_wr_done = 0;
  logic [527:0] mem_wr_data;
  logic [42:0]  mem_wr_addr;
  logic [11:0]  mem_wr_size;
  logic [1:0]   ack_vld, ack_rdy = 0;
  logic [16:0]  ack_pkt;
  logic         local_ack_vld, local_ack_err;
  logic [3:0]   local_ack_tag;
  logic [7:0]   err_cnt;

  tile_wr_responder #(.TILE_X(TX), .TILE_Y(TY), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_data(req_data), .req_addr(req_addr), .req_size(req_size),
    .req_src(req_src), .req_tag(req_tag), .mem_wr_en(mem_wr_en),
    .mem_wr_rdy(mem_wr_rdy), .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr),
    .mem_wr_size(mem_wr_size), .mem_wr_done(mem_wr_done), .ack_vld(ack_vld),
    .ack_rdy(ack_rdy), .ack_pkt(ack_pkt), .local_ack_vld(local_ack_vld),
    .local_ack_tag(local_ack_tag), .local_ack_err(local_ack_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [527:0] data;
    logic [32:0]  addr;
    logic [11:0]  size;
    logic [9:0]   src;
    logic [3:0]   tag;
  } req_t;
  req_t q[$];
  int tests = 0, fails = 0;
  logic [7:0] m_err = 0;

  task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [9:0] src, input logic [3:0] tag);
    req_t r;
    int n = 0;
    r.src = src;
    r.tag = tag;
    r.addr = {1'($urandom), 32'($urandom)};
    r.size = 12'($urandom);
    r.data = '0;
    for (int i = 0; i < 17; i++) r.data = {r.data[495:0], 32'($urandom)};
    req_vld = 1; req_data = r.data; req_addr = r.addr; req_size = r.size;
    req_src = src; req_tag = tag;
    while (!req_rdy && n < 100) begin @(negedge clk); n++; end
    chk("push_accepted", req_rdy, 1);
    @(negedge clk);
    req_vld = 0;
    if (n < 100) q.push_back(r);
  endtask

  // Retire the model head: issue handshake after rdy_dly, done at WAIT cycle done_at
  // (0 = never), ack accepted after ack_dly cycles of back-pressure.
  task automatic serve(input int rdy_dly, input int done_at, input int ack_dly);
    req_t h;
    int n = 0, k = 1;
    bit fin = 0, ee, el, xd;
    logic [1:0] ev;
    logic [4:0] sx, sy;
    logic [16:0] ep;
    h = q[0];
    while (!mem_wr_en && n < 20) begin @(negedge clk); n++; end
    chk("mem_wr_en_seen", mem_wr_en, 1);
    if (!mem_wr_en) begin h = q.pop_front(); return; end
    repeat (rdy_dly) begin @(negedge clk); chk("mem_wr_en_hold", mem_wr_en, 1); end
    chk("mem_wr_data", mem_wr_data, h.data);
    chk("mem_wr_addr", mem_wr_addr, {5'(TY), 5'(TX), h.addr});
    chk("mem_wr_size", mem_wr_size, h.size);
    mem_wr_rdy = 1;
    @(negedge clk);
    mem_wr_rdy = 0;
    chk("mem_wr_en_drop", mem_wr_en, 0);
    while (!fin) begin
      mem_wr_done = (k == done_at);
      @(negedge clk);
      mem_wr_done = 0;
      if (k == done_at || k == TO) fin = 1;
      else begin chk("wait_no_ack", {ack_vld, local_ack_vld}, 0); k++; end
    end
    ee = !(done_at >= 1 && done_at <= TO);
    if (ee && m_err != 8'hff) m_err++;
    sx = h.src[4:0]; sy = h.src[9:5];
    el = 0; xd = 0; ev = 2'b00;
    if (int'(sx) != TX) ev = int'(sx) > TX ? 2'b10 : 2'b01;
    else if (int'(sy) != TY) begin ev = int'(sy) > TY ? 2'b10 : 2'b01; xd = 1; end
    else el = 1;
    ep = {ee, 1'b0, xd, sy, sx, h.tag};
    chk("req_rdy_in_ack", req_rdy, q.size() != DEPTH);
    if (el) begin
      chk("local_ack_vld", local_ack_vld, 1);
      chk("local_ack_tag", local_ack_tag, h.tag);
      chk("local_ack_err", local_ack_err, ee);
      chk("ack_vld_local", ack_vld, 0);
      @(negedge clk);
    end else begin
      chk("ack_vld", ack_vld, ev);
      chk("ack_pkt", ack_pkt, ep);
      chk("local_ack_idle", local_ack_vld, 0);
      repeat (ack_dly) begin
        ack_rdy = ~ev;
        @(negedge clk);
        chk("ack_vld_hold", ack_vld, ev);
        chk("ack_pkt_hold", ack_pkt, ep);
      end
      ack_rdy = $urandom_range(1) ? 2'b11 : ev;
      @(negedge clk);
      ack_rdy = 0;
    end
    chk("ack_clear", {ack_vld, local_ack_vld}, 0);
    h = q.pop_front();
    chk("req_rdy_after_pop", req_rdy, q.size() != DEPTH);
    chk("err_cnt", err_cnt, m_err);
  endtask

  initial begin
    logic any;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_outputs", {mem_wr_en, mem_wr_data, mem_wr_addr, mem_wr_size}, 0);
    chk("rst_acks", {ack_vld, ack_pkt, local_ack_vld, local_ack_tag, local_ack_err, err_cnt}, 0);
    rst_n = 1;
    @(negedge clk);
    // single X-dimension request: issue latency of two cycles
    push({5'd0, 5'd3}, 4'd5);
    chk("latency_c1", mem_wr_en, 0);
    @(negedge clk);
    chk("latency_c2", mem_wr_en, 1);
    serve(0, 2, 0);
    serve_dummy_guard: begin end
    push({5'd0, 5'd1}, 4'd7);
    serve(1, 1, 3);
    push({5'd1, 5'd1}, 4'd9);
    serve(0, 1, 0);
    // fill with issue stalled, blocked 9th request, then wrap through 16 requests
    for (int i = 0; i < 8; i++) push({5'($urandom_range(3)), 5'($urandom_range(3))}, 4'(i));
    chk("full_req_rdy", req_rdy, 0);
    req_vld = 1; req_tag = 4'd8;
    repeat (3) begin @(negedge clk); chk("full_hold_rdy", req_rdy, 0); end
    req_vld = 0;
    for (int i = 8; i < 16; i++) begin
      serve($urandom_range(2), $urandom_range(1, 3), $urandom_range(2));
      push({5'($urandom_range(3)), 5'($urandom_range(3))}, 4'(i));
    end
    while (q.size() != 0) serve($urandom_range(2), $urandom_range(1, 3), $urandom_range(2));
    any = 0;
    repeat (5) begin @(negedge clk); any |= mem_wr_en; end
    chk("empty_no_issue", any, 0);
    // timeout boundaries
    push({5'd1, 5'd1}, 4'd1);
    serve(0, 0, 0);
    push({5'd2, 5'd1}, 4'd2);
    serve(0, TO, 1);
    push({5'd0, 5'd0}, 4'd3);
    serve(0, TO + 1, 0);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      push({5'($urandom_range(3)), 5'($urandom_range(3))}, 4'($urandom));
      if ($urandom_range(1)) push({5'($urandom_range(3)), 5'($urandom_range(3))}, 4'($urandom));
      while (q.size() != 0) serve($urandom_range(2), $urandom_range(5), $urandom_range(2));
    end
    // err_cnt saturation
    for (int i = 0; i < 256; i++) begin push({5'd1, 5'd1}, 4'(i)); serve(0, 0, 0); end
    chk("err_cnt_sat", err_cnt, 8'hff);
    // reset while a write is outstanding with four queued
    for (int i = 0; i < 4; i++) push({5'd0, 5'd2}, 4'(i));
    any = 0;
    for (int i = 0; i < 20 && !mem_wr_en; i++) @(negedge clk);
    mem_wr_rdy = 1;
    @(negedge clk);
    mem_wr_rdy = 0;
    rst_n = 0;
    #1;
    chk("mid_rst_mem_wr_en", mem_wr_en, 0);
    chk("mid_rst_req_rdy", req_rdy, 1);
    chk("mid_rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    mem_wr_done = 1;
    ack_rdy = 2'b11;
    repeat (10) begin @(negedge clk); any |= mem_wr_en | (|ack_vld) | local_ack_vld | !req_rdy; mem_wr_done = 0; end
    chk("post_rst_quiet", any, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
